// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small combinational DUT in ascending order,
// compares its sampled outputs against an expected truth table and records the results.
module truth_table_checker #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N_OUT*(2**N_IN)-1:0]   exp_table,
  output logic [N_IN-1:0]              dut_in,
  input  logic [N_OUT-1:0]             dut_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [N_IN:0]                err_count,
  output logic                         first_err_valid,
  output logic [N_IN-1:0]              first_err_idx,
  output logic [N_OUT*(2**N_IN)-1:0]   obs_table
);

  localparam int NV = 1 << N_IN;
  localparam int TW = N_OUT * NV;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_count_q, err_count_d;
  logic              fev_q, fev_d;
  logic [N_IN-1:0]   fei_q, fei_d;
  logic [TW-1:0]     obs_q, obs_d;

  logic [N_OUT-1:0]  exp_ent;
  logic              mismatch;
  logic [N_IN:0]     err_next;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dut_in_d    = dut_in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fev_d       = fev_q;
    fei_d       = fei_q;
    obs_d       = obs_q;
    exp_ent     = exp_table[int'(idx_q)*N_OUT +: N_OUT];
    mismatch    = (dut_out != exp_ent);
    err_next    = err_count_q + {{N_IN{1'b0}}, mismatch};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = '0;
          dut_in_d    = '0;
          err_count_d = '0;
          fev_d       = 1'b0;
          fei_d       = '0;
          pass_d      = 1'b0;
          obs_d       = '0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // abort takes priority over the sample, including on the final vector
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          obs_d[int'(idx_q)*N_OUT +: N_OUT] = dut_out;
          err_count_d = err_next;
          if (mismatch && !fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end
          if (idx_q == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_next == '0);
          end else begin
            idx_d    = idx_q + N_IN'(1);
            dut_in_d = idx_q + N_IN'(1);
            cnt_d    = '0;
            state_d  = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
      obs_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fev_q       <= fev_d;
      fei_q       <= fei_d;
      obs_q       <= obs_d;
    end
  end

  assign dut_in          = dut_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign obs_table       = obs_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: a 4-in/3-out sweeper (SETTLE=1) and a 3-in/2-out sweeper (SETTLE=3),
// each wrapped around a small behavioural combinational DUT.
module tb_truth_table_checker;

  logic clk;
  logic reset;

  // instance A: defaults
  logic        start_a, abort_a;
  logic [47:0] exp_a, obs_a;
  logic [3:0]  din_a, fei_a;
  logic [2:0]  dout_a;
  logic        busy_a, done_a, pass_a, fev_a;
  logic [4:0]  err_a;

  // instance B: N_IN=3, N_OUT=2, SETTLE=3
  logic        start_b, abort_b;
  logic [15:0] exp_b, obs_b;
  logic [2:0]  din_b, fei_b;
  logic [1:0]  dout_b;
  logic        busy_b, done_b, pass_b, fev_b;
  logic [3:0]  err_b;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct { logic [3:0] vin; logic [2:0] fgh; } vec_a_t;
  typedef struct { logic [2:0] vin; logic [1:0] pq;  } vec_b_t;
  vec_a_t va[16];
  vec_b_t vb[8];
  logic [47:0] clean_a;
  logic [15:0] clean_b;

  // f = AB | C~D, g = A^B^C^D, h = ~A~C | BD
  assign dout_a = {(din_a[3] & din_a[2]) | (din_a[1] & ~din_a[0]),
                   din_a[3] ^ din_a[2] ^ din_a[1] ^ din_a[0],
                   (~din_a[3] & ~din_a[1]) | (din_a[2] & din_a[0])};
  // p = A^B^C, q = BC
  assign dout_b = {din_b[2] ^ din_b[1] ^ din_b[0], din_b[1] & din_b[0]};

  truth_table_checker u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .exp_table(exp_a), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_valid(fev_a), .first_err_idx(fei_a), .obs_table(obs_a)
  );

  truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .exp_table(exp_b), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_valid(fev_b), .first_err_idx(fei_b), .obs_table(obs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse, then follow dut_in/done/busy edge by edge (k = edges after start edge)
  task automatic sweep_a();
    start_a = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      tick();
      if (k == 0) start_a = 1'b0;
      chk("din_a", 64'(din_a), (k < 32) ? 64'(k / 2) : 64'd15);
      chk("done_a", 64'(done_a), 64'(k == 32));
      chk("busy_a", 64'(busy_a), 64'(k < 32));
    end
  endtask

  task automatic results_a(input logic p, input logic [4:0] e, input logic v, input logic [3:0] f);
    chk("pass_a", 64'(pass_a), 64'(p));
    chk("err_count_a", 64'(err_a), 64'(e));
    chk("first_err_valid_a", 64'(fev_a), 64'(v));
    chk("first_err_idx_a", 64'(fei_a), 64'(f));
  endtask

  initial begin
    // hand-computed truth tables, entry = {f,g,h} / {p,q}
    va[0]  = '{4'd0,  3'b001}; va[1]  = '{4'd1,  3'b011};
    va[2]  = '{4'd2,  3'b110}; va[3]  = '{4'd3,  3'b000};
    va[4]  = '{4'd4,  3'b011}; va[5]  = '{4'd5,  3'b001};
    va[6]  = '{4'd6,  3'b100}; va[7]  = '{4'd7,  3'b011};
    va[8]  = '{4'd8,  3'b010}; va[9]  = '{4'd9,  3'b000};
    va[10] = '{4'd10, 3'b100}; va[11] = '{4'd11, 3'b010};
    va[12] = '{4'd12, 3'b100}; va[13] = '{4'd13, 3'b111};
    va[14] = '{4'd14, 3'b110}; va[15] = '{4'd15, 3'b101};
    vb[0] = '{3'd0, 2'b00}; vb[1] = '{3'd1, 2'b10};
    vb[2] = '{3'd2, 2'b10}; vb[3] = '{3'd3, 2'b01};
    vb[4] = '{3'd4, 2'b10}; vb[5] = '{3'd5, 2'b00};
    vb[6] = '{3'd6, 2'b00}; vb[7] = '{3'd7, 2'b11};
    clean_a = '0;
    clean_b = '0;
    for (int i = 0; i < 16; i++) clean_a[int'(va[i].vin)*3 +: 3] = va[i].fgh;
    for (int i = 0; i < 8; i++)  clean_b[int'(vb[i].vin)*2 +: 2] = vb[i].pq;

    start_a = 1'b0; abort_a = 1'b0; exp_a = clean_a;
    start_b = 1'b0; abort_b = 1'b0; exp_b = clean_b;
    reset = 1'b0;

    // reset state
    #2;
    chk("rst_din_a", 64'(din_a), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_pass_a", 64'(pass_a), 64'd0);
    chk("rst_err_a", 64'(err_a), 64'd0);
    chk("rst_obs_a", 64'(obs_a), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    chk("rst_obs_b", 64'(obs_b), 64'd0);
    #1 reset = 1'b1;
    tick();
    tick();

    // clean sweep: table-driven check of the captured truth table
    exp_a = clean_a;
    sweep_a();
    results_a(1'b1, 5'd0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("obs_a[%0d]", va[i].vin), 64'(obs_a[int'(va[i].vin)*3 +: 3]), 64'(va[i].fgh));

    // single flipped expectation: entry 5 bit 1
    exp_a = clean_a;
    exp_a[5*3 + 1] = ~exp_a[5*3 + 1];
    sweep_a();
    results_a(1'b0, 5'd1, 1'b1, 4'd5);
    chk("obs_a[5]_true", 64'(obs_a[15 +: 3]), 64'(va[5].fgh));

    // every entry wrong
    exp_a = ~clean_a;
    sweep_a();
    results_a(1'b0, 5'd16, 1'b1, 4'd0);
    chk("obs_a_all", 64'(obs_a), 64'(clean_a));

    // instance B: start held for 5 cycles -> exactly one sweep, 4 cycles per vector
    start_b = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (k == 4) start_b = 1'b0;
      chk("din_b", 64'(din_b), (k < 32) ? 64'(k / 4) : 64'd7);
      chk("done_b", 64'(done_b), 64'(k == 32));
      chk("busy_b", 64'(busy_b), 64'(k < 32));
    end
    chk("pass_b", 64'(pass_b), 64'd1);
    chk("err_count_b", 64'(err_b), 64'd0);
    chk("first_err_valid_b", 64'(fev_b), 64'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("obs_b[%0d]", vb[i].vin), 64'(obs_b[int'(vb[i].vin)*2 +: 2]), 64'(vb[i].pq));

    // abort on the 10th edge after start
    exp_a = clean_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    chk("busy_a_pre_abort", 64'(busy_a), 64'd1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_busy_a", 64'(busy_a), 64'd0);
    chk("abort_done_a", 64'(done_a), 64'd0);
    chk("abort_pass_a", 64'(pass_a), 64'd0);
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("abort_no_done_a", 64'(done_a), 64'd0);
    end
    chk("abort_idle_busy_a", 64'(busy_a), 64'd0);
    sweep_a();
    results_a(1'b1, 5'd0, 1'b0, 4'd0);

    // abort while idle is ignored
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("idle_abort_pass_a", 64'(pass_a), 64'd1);
    chk("idle_abort_busy_a", 64'(busy_a), 64'd0);

    // asynchronous reset mid-sweep at idx=7, with mismatches already recorded
    exp_a = ~clean_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    chk("pre_rst_din_a", 64'(din_a), 64'd7);
    chk("pre_rst_err_a", 64'(err_a), 64'd7);
    chk("pre_rst_fev_a", 64'(fev_a), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_din_a", 64'(din_a), 64'd0);
    chk("mid_rst_busy_a", 64'(busy_a), 64'd0);
    chk("mid_rst_err_a", 64'(err_a), 64'd0);
    chk("mid_rst_fev_a", 64'(fev_a), 64'd0);
    chk("mid_rst_fei_a", 64'(fei_a), 64'd0);
    chk("mid_rst_pass_a", 64'(pass_a), 64'd0);
    chk("mid_rst_obs_a", 64'(obs_a), 64'd0);
    #2 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_busy_a", 64'(busy_a), 64'd0);
      chk("post_rst_din_a", 64'(din_a), 64'd0);
      chk("post_rst_done_a", 64'(done_a), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential self-checking sweeper for combinational blocks of the 4-input/3-output kind (f, g, h of A..D), generalised to N_IN inputs and N_OUT outputs.
- Drives every input vector 0..2^N_IN-1 onto the DUT in ascending order, waits a programmable settle time, then samples the DUT outputs.
- Compares each sample against a programmed expected truth table, counts mismatches and records the first failing vector.
- Captures the observed truth table so a bench can dump it. Sits in benches and on-board self-test, between a stimulus/start source and the combinational DUT.

Parameters:
- N_IN, 4, number of DUT inputs; vectors 0..2^N_IN-1; range 1..8.
- N_OUT, 3, number of DUT outputs; range 1..8.
- SETTLE, 1, clock cycles each vector is held before sampling; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a sweep in progress.
- exp_table  input  N_OUT*2^N_IN  expected outputs; entry i at [i*N_OUT +: N_OUT]; MSB of entry = first DUT output (f); must be stable while busy.
- dut_in  output  N_IN  vector driven to the DUT; MSB = first input (A).
- dut_out  input  N_OUT  DUT outputs.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  last completed sweep had zero mismatches.
- err_count  output  N_IN+1  number of mismatching vectors in the current/last sweep.
- first_err_valid  output  1  at least one mismatch recorded.
- first_err_idx  output  N_IN  index of the first mismatching vector.
- obs_table  output  N_OUT*2^N_IN  captured DUT outputs, same layout as exp_table.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx and obs_table. Internal idx and settle counter are also 0.
- All outputs are registered. FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at edge E:
  - idx←0, dut_in←0, err_count←0, first_err_valid←0, first_err_idx←0, pass←0, obs_table←0.
  - busy←1; settle counter←0; state←SETTLE.
- SETTLE: settle counter increments each edge. When counter = SETTLE-1, state←CHECK. The vector is therefore held exactly SETTLE cycles before the CHECK cycle.
- CHECK (one cycle), sampling dut_out:
  - obs_table entry idx←dut_out.
  - If dut_out ≠ exp_table entry idx: err_count←err_count+1. If first_err_valid=0: first_err_idx←idx, first_err_valid←1.
  - If idx = 2^N_IN-1: state←DONE. Otherwise idx←idx+1, dut_in←idx+1, counter←0, state←SETTLE.
- Each vector occupies SETTLE+1 cycles. DONE is entered at edge E + 2^N_IN*(SETTLE+1).
- DONE, on entry:
  - done←1 and busy←0.
  - pass←1 if err_count (including the last CHECK) = 0.
  - Next edge: done←0, state←IDLE.
  - Results and dut_in hold until the next start.
- err_count cannot overflow (max 2^N_IN fits N_IN+1 bits).
- start while not in IDLE is ignored, including in the DONE cycle.
- abort=1 in SETTLE/CHECK: next edge state←IDLE, busy←0, done stays 0, pass←0. err_count, first_err and obs_table keep their partial values. abort in IDLE/DONE has no effect.
- abort and the final CHECK on the same edge: abort wins; no done pulse.
- reset asserted mid-sweep: immediate return to the reset values. A new start is required after release.
- exp_table changes during busy are not supported; only the value sampled at each CHECK matters.

Test Plan:
- Defaults, behavioural DUT f/g/h with exp_table programmed to match; pulse start → dut_in steps 0..15, each held 2 cycles. done pulses exactly 32 edges after the start edge; pass=1, err_count=0, first_err_valid=0, obs_table=exp_table.
- Same setup, exp_table entry 5 bit 1 flipped → err_count=1, first_err_valid=1, first_err_idx=5, pass=0. obs_table entry 5 holds the true DUT value.
- exp_table = bitwise NOT of the DUT table → err_count=16, first_err_idx=0, pass=0.
- SETTLE=3, N_IN=3, N_OUT=2, start held high for 5 cycles → a single sweep only; dut_in 0..7 each held 4 cycles; done 32 edges after the start edge.
- abort at the 10th cycle after start → busy=0 next edge, no done pulse, pass=0. A new start then completes a clean sweep with pass=1.
- reset low mid-sweep (idx=7) → all outputs 0 without a clock edge. After release, outputs remain idle until start.
